// File: rtl/fsm_pkg.sv
// Shared constants for the FSM processor: phase codes, opcodes and ALU-op encoding.
package fsm_pkg;

  localparam logic [2:0] PH_FETCH  = 3'b000;
  localparam logic [2:0] PH_DECODE = 3'b001;
  localparam logic [2:0] PH_EXEC   = 3'b010;
  localparam logic [2:0] PH_SHORT  = 3'b011;
  localparam logic [2:0] PH_WB     = 3'b100;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_HALT = 4'h6;
  localparam logic [3:0] OP_AND  = 4'h7;

  typedef enum logic [1:0] {
    ALU_LDI = 2'b00,
    ALU_ADD = 2'b01,
    ALU_SUB = 2'b10,
    ALU_AND = 2'b11
  } alu_op_e;

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Bus between the fetch/decode unit, the phase controller, program ROM and datapath.
interface fetch_decode_unit_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [2:0]         state;
  logic [INSTR_W-1:0] rom_data;
  logic               flag_z;
  logic [ADDR_W-1:0]  rom_addr;
  logic               short_op;
  logic               instr_valid;
  logic               alu_en;
  logic               wb_en;
  logic [1:0]         alu_op;
  logic [ADDR_W-1:0]  imm;
  logic               halted;
  logic               illegal;
  logic [15:0]        retired;

  modport master (
    output state, rom_data, flag_z,
    input  rom_addr, short_op, instr_valid, alu_en, wb_en, alu_op, imm,
           halted, illegal, retired
  );

  modport slave (
    input  state, rom_data, flag_z,
    output rom_addr, short_op, instr_valid, alu_en, wb_en, alu_op, imm,
           halted, illegal, retired
  );
endinterface

// File: rtl/op_classify.sv
// Combinational opcode classifier. Illegal opcodes take the short path, so is_short covers them.
module op_classify
  import fsm_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       is_short,
  output logic       is_illegal,
  output logic [1:0] alu_op
);

  always_comb begin
    is_short   = 1'b0;
    is_illegal = 1'b0;
    alu_op     = ALU_LDI;
    case (opcode)
      OP_NOP, OP_JMP, OP_JZ, OP_HALT: is_short = 1'b1;
      OP_LDI: alu_op = ALU_LDI;
      OP_ADD: alu_op = ALU_ADD;
      OP_SUB: alu_op = ALU_SUB;
      OP_AND: alu_op = ALU_AND;
      default: begin
        is_short   = 1'b1;
        is_illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fetch_decode_unit.sv
// Fetch/decode unit: owns PC, IR and retirement counter; acts on the controller's phase code.
module fetch_decode_unit
  import fsm_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                clk,
  input logic                rst,
  fetch_decode_unit_if.slave bus
);

  logic [ADDR_W-1:0]  pc_reg;
  logic [INSTR_W-1:0] ir_reg;
  logic [1:0]         alu_op_reg;
  logic               aligned_reg;
  logic               halted_reg;
  logic               illegal_reg;
  logic [15:0]        retired_reg;

  logic               rom_is_short, rom_is_illegal;
  logic [1:0]         rom_alu_op;
  logic               ir_is_short, ir_is_illegal;
  logic [1:0]         ir_alu_op;

  logic [ADDR_W-1:0]  pc_inc_next;
  logic [ADDR_W-1:0]  target;
  logic [15:0]        retired_next;
  logic               fetch_ok, run, ir_long;
  logic               unused_bits;

  op_classify u_rom_class (
    .opcode     (bus.rom_data[INSTR_W-1 -: 4]),
    .is_short   (rom_is_short),
    .is_illegal (rom_is_illegal),
    .alu_op     (rom_alu_op)
  );

  op_classify u_ir_class (
    .opcode     (ir_reg[INSTR_W-1 -: 4]),
    .is_short   (ir_is_short),
    .is_illegal (ir_is_illegal),
    .alu_op     (ir_alu_op)
  );

  assign unused_bits  = ^{rom_is_illegal, rom_alu_op, ir_reg[INSTR_W-5:ADDR_W]};

  assign pc_inc_next  = pc_reg + ADDR_W'(1);
  assign target       = ir_reg[ADDR_W-1:0];
  assign retired_next = (retired_reg == 16'hFFFF) ? retired_reg : retired_reg + 16'd1;
  assign ir_long      = !ir_is_short;

  // A FETCH is honoured even before alignment; every other phase needs aligned_reg.
  assign fetch_ok = !rst && !halted_reg && (bus.state == PH_FETCH);
  assign run      = !rst && !halted_reg && aligned_reg;

  assign bus.instr_valid = fetch_ok;
  assign bus.short_op    = fetch_ok && rom_is_short;
  assign bus.alu_en      = run && (bus.state == PH_EXEC) && ir_long;
  assign bus.wb_en       = run && (bus.state == PH_WB) && ir_long;
  assign bus.rom_addr    = pc_reg;
  assign bus.imm         = ir_reg[ADDR_W-1:0];
  assign bus.alu_op      = alu_op_reg;
  assign bus.halted      = halted_reg;
  assign bus.illegal     = illegal_reg;
  assign bus.retired     = retired_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg      <= RESET_PC;
      ir_reg      <= '0;
      alu_op_reg  <= ALU_LDI;
      aligned_reg <= 1'b0;
      halted_reg  <= 1'b0;
      illegal_reg <= 1'b0;
      retired_reg <= '0;
    end else if (!halted_reg) begin
      case (bus.state)
        PH_FETCH: begin
          aligned_reg <= 1'b1;
          ir_reg      <= bus.rom_data;
        end
        PH_DECODE: begin
          if (aligned_reg && ir_long) alu_op_reg <= ir_alu_op;
        end
        PH_WB: begin
          if (aligned_reg && ir_long) begin
            pc_reg      <= pc_inc_next;
            retired_reg <= retired_next;
          end
        end
        // Short path: mismatched (long) opcodes here leave all state untouched.
        PH_SHORT: begin
          if (aligned_reg && ir_is_short) begin
            retired_reg <= retired_next;
            case (ir_reg[INSTR_W-1 -: 4])
              OP_JMP:  pc_reg     <= target;
              OP_JZ:   pc_reg     <= bus.flag_z ? target : pc_inc_next;
              OP_HALT: halted_reg <= 1'b1;
              default: begin
                pc_reg <= pc_inc_next;
                if (ir_is_illegal) illegal_reg <= 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: directed vector table, hand sequences and a randomized run against a model.
module tb_fetch_decode_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_decode_unit_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  fetch_decode_unit #(.ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] rom [256];
  assign bus.rom_data = rom[bus.rom_addr];

  int n_checks = 0;
  int n_fail   = 0;
  logic c_short, c_valid, c_alu, c_wb;

  typedef struct {
    logic [2:0]  ph;
    logic        fz;
    logic        e_short, e_valid, e_alu, e_wb;
    logic [7:0]  e_pc;
    logic [15:0] e_ret;
    logic        e_halt, e_ill;
    logic [1:0]  e_aluop;
    logic [7:0]  e_imm;
  } vec_t;
  vec_t vecs[26];

  // Reference model state
  logic [7:0]  m_pc;
  logic [15:0] m_ir;
  logic [1:0]  m_aluop;
  logic [15:0] m_ret;
  logic        m_halt, m_ill;

  function automatic logic m_is_short(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd4) || (op == 4'd5) || (op == 4'd6) || (op >= 4'd8);
  endfunction

  function automatic logic [1:0] m_alu(input logic [3:0] op);
    case (op)
      4'd2:    return 2'd1;
      4'd3:    return 2'd2;
      4'd7:    return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One controller cycle: drive at negedge, capture combinational outputs, return just after the edge.
  task automatic run_phase(input logic [2:0] ph, input logic fz, input logic r);
    @(negedge clk);
    bus.state  = ph;
    bus.flag_z = fz;
    rst        = r;
    #2;
    c_short = bus.short_op;
    c_valid = bus.instr_valid;
    c_alu   = bus.alu_en;
    c_wb    = bus.wb_en;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic sh, va, al, wb,
                              input logic [7:0] pc, input logic [15:0] ret, input logic h, il);
    check({tag, ".short_op"},    c_short, sh);
    check({tag, ".instr_valid"}, c_valid, va);
    check({tag, ".alu_en"},      c_alu, al);
    check({tag, ".wb_en"},       c_wb, wb);
    check({tag, ".pc"},          bus.rom_addr, pc);
    check({tag, ".retired"},     bus.retired, ret);
    check({tag, ".halted"},      bus.halted, h);
    check({tag, ".illegal"},     bus.illegal, il);
  endtask

  task automatic model_check(input string tag, input logic sh, va, al, wb);
    expect_state(tag, sh, va, al, wb, m_pc, m_ret, m_halt, m_ill);
    check({tag, ".alu_op"}, bus.alu_op, m_aluop);
    check({tag, ".imm"},    bus.imm, m_ir[7:0]);
  endtask

  task automatic model_reset(input logic [2:0] ph);
    run_phase(ph, 1'b0, 1'b1);
    m_pc = 8'h00; m_ir = 16'h0000; m_aluop = 2'd0; m_ret = 16'd0; m_halt = 1'b0; m_ill = 1'b0;
    model_check("rnd_reset", 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] word;
    logic [3:0]  op;
    logic        fz;
    logic [2:0]  ph;

    bus.state  = 3'b000;
    bus.flag_z = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h2005;
    rom[8'h01] = 16'h403C;
    rom[8'h3C] = 16'h5010;
    rom[8'h10] = 16'h5010;
    rom[8'h11] = 16'hF000;
    rom[8'h12] = 16'h40FF;
    rom[8'hFF] = 16'h0000;

    //            ph     fz  sh va al wb  pc     ret     h  il  aop   imm
    vecs[0]  = '{3'b100, 0, 0, 0, 0, 0, 8'h00, 16'd0, 0, 0, 2'd0, 8'h00};
    vecs[1]  = '{3'b000, 0, 0, 1, 0, 0, 8'h00, 16'd0, 0, 0, 2'd0, 8'h05};
    vecs[2]  = '{3'b001, 0, 0, 0, 0, 0, 8'h00, 16'd0, 0, 0, 2'd1, 8'h05};
    vecs[3]  = '{3'b010, 0, 0, 0, 1, 0, 8'h00, 16'd0, 0, 0, 2'd1, 8'h05};
    vecs[4]  = '{3'b100, 0, 0, 0, 0, 1, 8'h01, 16'd1, 0, 0, 2'd1, 8'h05};
    vecs[5]  = '{3'b000, 0, 1, 1, 0, 0, 8'h01, 16'd1, 0, 0, 2'd1, 8'h3C};
    vecs[6]  = '{3'b011, 0, 0, 0, 0, 0, 8'h3C, 16'd2, 0, 0, 2'd1, 8'h3C};
    vecs[7]  = '{3'b000, 0, 1, 1, 0, 0, 8'h3C, 16'd2, 0, 0, 2'd1, 8'h10};
    vecs[8]  = '{3'b011, 1, 0, 0, 0, 0, 8'h10, 16'd3, 0, 0, 2'd1, 8'h10};
    vecs[9]  = '{3'b000, 0, 1, 1, 0, 0, 8'h10, 16'd3, 0, 0, 2'd1, 8'h10};
    vecs[10] = '{3'b011, 0, 0, 0, 0, 0, 8'h11, 16'd4, 0, 0, 2'd1, 8'h10};
    vecs[11] = '{3'b000, 0, 1, 1, 0, 0, 8'h11, 16'd4, 0, 0, 2'd1, 8'h00};
    vecs[12] = '{3'b011, 0, 0, 0, 0, 0, 8'h12, 16'd5, 0, 1, 2'd1, 8'h00};
    vecs[13] = '{3'b000, 0, 1, 1, 0, 0, 8'h12, 16'd5, 0, 1, 2'd1, 8'hFF};
    vecs[14] = '{3'b011, 0, 0, 0, 0, 0, 8'hFF, 16'd6, 0, 1, 2'd1, 8'hFF};
    vecs[15] = '{3'b000, 0, 1, 1, 0, 0, 8'hFF, 16'd6, 0, 1, 2'd1, 8'h00};
    vecs[16] = '{3'b110, 0, 0, 0, 0, 0, 8'hFF, 16'd6, 0, 1, 2'd1, 8'h00};
    vecs[17] = '{3'b011, 0, 0, 0, 0, 0, 8'h00, 16'd7, 0, 1, 2'd1, 8'h00};
    vecs[18] = '{3'b000, 0, 0, 1, 0, 0, 8'h00, 16'd7, 0, 1, 2'd1, 8'h05};
    vecs[19] = '{3'b011, 0, 0, 0, 0, 0, 8'h00, 16'd7, 0, 1, 2'd1, 8'h05};
    vecs[20] = '{3'b010, 0, 0, 0, 1, 0, 8'h00, 16'd7, 0, 1, 2'd1, 8'h05};
    vecs[21] = '{3'b100, 0, 0, 0, 0, 1, 8'h01, 16'd8, 0, 1, 2'd1, 8'h05};
    vecs[22] = '{3'b000, 0, 1, 1, 0, 0, 8'h01, 16'd8, 0, 1, 2'd1, 8'h3C};
    vecs[23] = '{3'b100, 0, 0, 0, 0, 0, 8'h01, 16'd8, 0, 1, 2'd1, 8'h3C};
    vecs[24] = '{3'b010, 0, 0, 0, 0, 0, 8'h01, 16'd8, 0, 1, 2'd1, 8'h3C};
    vecs[25] = '{3'b011, 0, 0, 0, 0, 0, 8'h3C, 16'd9, 0, 1, 2'd1, 8'h3C};

    // Reset with a FETCH phase present: reset wins, nothing is fetched.
    run_phase(3'b000, 1'b0, 1'b1);
    run_phase(3'b000, 1'b0, 1'b1);
    expect_state("reset", 0, 0, 0, 0, 8'h00, 16'd0, 0, 0);
    check("reset.alu_op", bus.alu_op, 2'd0);
    check("reset.imm", bus.imm, 8'h00);
    $display("txn reset pc=%02h retired=%0d", bus.rom_addr, bus.retired);

    for (int i = 0; i < 26; i++) begin
      run_phase(vecs[i].ph, vecs[i].fz, 1'b0);
      expect_state($sformatf("vec%0d", i), vecs[i].e_short, vecs[i].e_valid, vecs[i].e_alu,
                   vecs[i].e_wb, vecs[i].e_pc, vecs[i].e_ret, vecs[i].e_halt, vecs[i].e_ill);
      check($sformatf("vec%0d.alu_op", i), bus.alu_op, vecs[i].e_aluop);
      check($sformatf("vec%0d.imm", i), bus.imm, vecs[i].e_imm);
      $display("txn vec%0d ph=%03b pc=%02h retired=%0d", i, vecs[i].ph, bus.rom_addr, bus.retired);
    end

    // HALT at pc=5: sticky, freezes pc/ir/retired, only reset clears it.
    rom[8'h00] = 16'h4005;
    rom[8'h05] = 16'h6000;
    run_phase(3'b011, 1'b0, 1'b1);
    expect_state("halt.rst", 0, 0, 0, 0, 8'h00, 16'd0, 0, 0);
    run_phase(3'b000, 1'b0, 1'b0);
    expect_state("halt.f0", 1, 1, 0, 0, 8'h00, 16'd0, 0, 0);
    run_phase(3'b011, 1'b0, 1'b0);
    expect_state("halt.s0", 0, 0, 0, 0, 8'h05, 16'd1, 0, 0);
    run_phase(3'b000, 1'b0, 1'b0);
    expect_state("halt.f1", 1, 1, 0, 0, 8'h05, 16'd1, 0, 0);
    run_phase(3'b011, 1'b0, 1'b0);
    expect_state("halt.s1", 0, 0, 0, 0, 8'h05, 16'd2, 1, 0);
    rom[8'h05] = 16'h2077;
    run_phase(3'b000, 1'b0, 1'b0);
    expect_state("halt.f2", 0, 0, 0, 0, 8'h05, 16'd2, 1, 0);
    check("halt.imm_frozen", bus.imm, 8'h00);
    run_phase(3'b001, 1'b0, 1'b0);
    run_phase(3'b010, 1'b0, 1'b0);
    expect_state("halt.exec", 0, 0, 0, 0, 8'h05, 16'd2, 1, 0);
    run_phase(3'b100, 1'b0, 1'b0);
    expect_state("halt.wb", 0, 0, 0, 0, 8'h05, 16'd2, 1, 0);
    check("halt.alu_op", bus.alu_op, 2'd0);
    run_phase(3'b000, 1'b0, 1'b1);
    expect_state("halt.clear", 0, 0, 0, 0, 8'h00, 16'd0, 0, 0);
    $display("txn halt sequence done pc=%02h", bus.rom_addr);

    // Reset during EXEC, phases resume at WRITEBACK then SHORT: ignored until the next FETCH.
    rom[8'h00] = 16'h2005;
    rom[8'h01] = 16'h1042;
    run_phase(3'b000, 1'b0, 1'b0);
    run_phase(3'b001, 1'b0, 1'b0);
    run_phase(3'b010, 1'b0, 1'b0);
    run_phase(3'b100, 1'b0, 1'b0);
    expect_state("mid.add", 0, 0, 0, 1, 8'h01, 16'd1, 0, 0);
    run_phase(3'b000, 1'b0, 1'b0);
    expect_state("mid.f", 0, 1, 0, 0, 8'h01, 16'd1, 0, 0);
    run_phase(3'b001, 1'b0, 1'b0);
    check("mid.alu_op_ldi", bus.alu_op, 2'd0);
    run_phase(3'b010, 1'b0, 1'b1);
    expect_state("mid.rst", 0, 0, 0, 0, 8'h00, 16'd0, 0, 0);
    run_phase(3'b100, 1'b0, 1'b0);
    expect_state("mid.wb", 0, 0, 0, 0, 8'h00, 16'd0, 0, 0);
    run_phase(3'b011, 1'b0, 1'b0);
    expect_state("mid.short", 0, 0, 0, 0, 8'h00, 16'd0, 0, 0);
    run_phase(3'b000, 1'b0, 1'b0);
    expect_state("mid.f2", 0, 1, 0, 0, 8'h00, 16'd0, 0, 0);
    check("mid.imm", bus.imm, 8'h05);
    run_phase(3'b001, 1'b0, 1'b0);
    run_phase(3'b010, 1'b0, 1'b0);
    expect_state("mid.exec", 0, 0, 1, 0, 8'h00, 16'd0, 0, 0);
    run_phase(3'b100, 1'b0, 1'b0);
    expect_state("mid.wb2", 0, 0, 0, 1, 8'h01, 16'd1, 0, 0);
    $display("txn reset-mid sequence done pc=%02h", bus.rom_addr);

    // Randomized program against the reference model.
    for (int i = 0; i < 256; i++) rom[i] = 16'($urandom);
    model_reset(3'($urandom_range(0, 7)));
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        ph = 3'($urandom_range(5, 7));
        run_phase(ph, 1'($urandom), 1'b0);
        model_check("rnd_junk", 0, 0, 0, 0);
      end
      if (m_halt) begin
        if ($urandom_range(0, 3) == 0) begin
          model_reset(3'($urandom_range(0, 7)));
          if ($urandom_range(0, 1) == 1) begin
            run_phase(3'($urandom_range(1, 7)), 1'($urandom), 1'b0);
            model_check("rnd_unaligned", 0, 0, 0, 0);
          end
        end else begin
          run_phase(3'b000, 1'b0, 1'b0);
          model_check("rnd_hfetch", 0, 0, 0, 0);
          run_phase(3'b001, 1'b0, 1'b0);
          run_phase(3'b010, 1'b0, 1'b0);
          model_check("rnd_hexec", 0, 0, 0, 0);
          run_phase(3'b100, 1'b0, 1'b0);
          model_check("rnd_hwb", 0, 0, 0, 0);
        end
        $display("txn rnd%0d halted pc=%02h", n, m_pc);
        continue;
      end
      word = rom[m_pc];
      op   = word[15:12];
      m_ir = word;
      run_phase(3'b000, 1'b0, 1'b0);
      model_check("rnd_fetch", m_is_short(op), 1, 0, 0);
      if (m_is_short(op)) begin
        fz = 1'($urandom);
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
        if (op == 4'd4)      m_pc = word[7:0];
        else if (op == 4'd5) m_pc = fz ? word[7:0] : m_pc + 8'd1;
        else if (op == 4'd6) m_halt = 1'b1;
        else begin
          m_pc = m_pc + 8'd1;
          if (op >= 4'd8) m_ill = 1'b1;
        end
        run_phase(3'b011, fz, 1'b0);
        model_check("rnd_short", 0, 0, 0, 0);
      end else begin
        m_aluop = m_alu(op);
        run_phase(3'b001, 1'($urandom), 1'b0);
        model_check("rnd_decode", 0, 0, 0, 0);
        run_phase(3'b010, 1'($urandom), 1'b0);
        model_check("rnd_exec", 0, 0, 1, 0);
        m_pc = m_pc + 8'd1;
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
        run_phase(3'b100, 1'($urandom), 1'b0);
        model_check("rnd_wb", 0, 0, 0, 1);
      end
      $display("txn rnd%0d op=%h word=%04h pc=%02h retired=%0d", n, op, word, m_pc, m_ret);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
